// File: rtl/plot_framebuffer.sv
// Purpose: captures plotter pixels into a WIDTHxHEIGHT 3-bit framebuffer, with bulk clear and raster readout scan.
// Latency: plot written at the next edge; first scan pixel 2 cycles after scan_start, then one pixel per cycle.
// Backpressure: none; plots arriving while busy are dropped and counted in oob_count, starts while busy are ignored.
module plot_framebuffer #(
    parameter int WIDTH  = 160,
    parameter int HEIGHT = 120,
    parameter int CNT_W  = 15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       vga_x,
    input  logic [6:0]       vga_y,
    input  logic [2:0]       vga_colour,
    input  logic             vga_plot,
    input  logic             clear_start,
    input  logic [2:0]       clear_colour,
    input  logic             scan_start,
    output logic             busy,
    output logic             rd_valid,
    output logic [7:0]       rd_x,
    output logic [6:0]       rd_y,
    output logic [2:0]       rd_colour,
    output logic             op_done,
    output logic [CNT_W-1:0] plot_count,
    output logic [7:0]       oob_count
);

    localparam int         DEPTH   = WIDTH * HEIGHT;
    localparam int         AW      = $clog2(DEPTH);
    localparam logic [7:0] LP_XLIM  = 8'(WIDTH);
    localparam logic [6:0] LP_YLIM  = 7'(HEIGHT);
    localparam logic [7:0] LP_XLAST = 8'(WIDTH - 1);
    localparam logic [6:0] LP_YLAST = 7'(HEIGHT - 1);

    typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_SCAN} state_t;

    state_t          r_state;
    state_t          w_next;

    logic [2:0]      r_mem [0:DEPTH-1];
    logic [2:0]      r_mem_q;
    logic [7:0]      r_cx;
    logic [6:0]      r_cy;
    logic [AW-1:0]   r_addr;
    logic            r_iss;
    logic            r_drain;
    logic [2:0]      r_clr_col;
    logic            r_op_done;
    logic            r_rd_valid;
    logic [7:0]      r_rd_x;
    logic [6:0]      r_rd_y;
    logic            r_rd_seen;
    logic [CNT_W-1:0] r_plot_cnt;
    logic [7:0]      r_oob_cnt;

    logic            w_in_range;
    logic            w_plot_ok;
    logic            w_start_clr;
    logic            w_start_scan;
    logic            w_last;
    logic            w_iss;
    logic            w_we;
    logic [AW-1:0]   w_waddr;
    logic [2:0]      w_wdat;
    logic [AW-1:0]   w_plot_addr;

    assign w_in_range   = (vga_x < LP_XLIM) && (vga_y < LP_YLIM);
    assign w_plot_ok    = (r_state == S_IDLE) && vga_plot && w_in_range;
    assign w_start_clr  = (r_state == S_IDLE) && clear_start;
    assign w_start_scan = (r_state == S_IDLE) && scan_start && !clear_start;
    assign w_last       = (r_cx == LP_XLAST) && (r_cy == LP_YLAST);
    assign w_iss        = (r_state == S_SCAN) && r_iss;
    assign w_plot_addr  = AW'(vga_y) * AW'(WIDTH) + AW'(vga_x);
    // Reset is gated in so an abort edge can never land a stray clear write.
    assign w_we         = !rst && (w_plot_ok || (r_state == S_CLEAR));
    assign w_waddr      = (r_state == S_CLEAR) ? r_addr : w_plot_addr;
    assign w_wdat       = (r_state == S_CLEAR) ? r_clr_col : vga_colour;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next state: clear beats scan when both start together; scan holds one extra drain cycle.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_clr)       w_next = S_CLEAR;
                else if (w_start_scan) w_next = S_SCAN;
            end
            S_CLEAR: if (w_last)  w_next = S_IDLE;
            S_SCAN:  if (r_drain) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Raster walker: shared x/y/address counters, scan prime/drain flags and readout registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cx       <= '0;
            r_cy       <= '0;
            r_addr     <= '0;
            r_iss      <= 1'b0;
            r_drain    <= 1'b0;
            r_clr_col  <= '0;
            r_op_done  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_x     <= '0;
            r_rd_y     <= '0;
            r_rd_seen  <= 1'b0;
        end else begin
            r_op_done  <= 1'b0;
            r_rd_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_clr) r_clr_col <= clear_colour;
                    if (w_start_clr || w_start_scan) begin
                        r_cx    <= '0;
                        r_cy    <= '0;
                        r_addr  <= '0;
                        r_iss   <= 1'b0;
                        r_drain <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    if (r_cx == LP_XLAST) begin
                        r_cx <= '0;
                        r_cy <= r_cy + 7'd1;
                    end else begin
                        r_cx <= r_cx + 8'd1;
                    end
                    r_addr <= r_addr + 1'b1;
                    if (w_last) r_op_done <= 1'b1;
                end
                S_SCAN: begin
                    if (r_drain) begin
                        r_drain <= 1'b0;
                    end else if (!r_iss) begin
                        // First scan cycle only primes the read pipeline.
                        r_iss <= 1'b1;
                    end else begin
                        r_rd_valid <= 1'b1;
                        r_rd_x     <= r_cx;
                        r_rd_y     <= r_cy;
                        r_rd_seen  <= 1'b1;
                        if (r_cx == LP_XLAST) begin
                            r_cx <= '0;
                            r_cy <= r_cy + 7'd1;
                        end else begin
                            r_cx <= r_cx + 8'd1;
                        end
                        r_addr <= r_addr + 1'b1;
                        if (w_last) begin
                            r_iss     <= 1'b0;
                            r_drain   <= 1'b1;
                            r_op_done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Framebuffer storage: one write port, one registered read port, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_we)  r_mem[w_waddr] <= w_wdat;
        if (w_iss) r_mem_q <= r_mem[r_addr];
    end

    // Saturating statistics: accepted plots, and plots that were out of range or arrived while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_plot_cnt <= '0;
            r_oob_cnt  <= '0;
        end else if (vga_plot) begin
            if (w_plot_ok) begin
                if (r_plot_cnt != '1) r_plot_cnt <= r_plot_cnt + 1'b1;
            end else begin
                if (r_oob_cnt != '1) r_oob_cnt <= r_oob_cnt + 8'd1;
            end
        end
    end

    assign busy       = (r_state != S_IDLE);
    assign rd_valid   = r_rd_valid;
    assign rd_x       = r_rd_x;
    assign rd_y       = r_rd_y;
    assign rd_colour  = r_rd_seen ? r_mem_q : 3'b000;
    assign op_done    = r_op_done;
    assign plot_count = r_plot_cnt;
    assign oob_count  = r_oob_cnt;

endmodule

// File: tb/tb_plot_framebuffer.sv
module tb_plot_framebuffer;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic        clear_start;
    logic [2:0]  clear_colour;
    logic        scan_start;
    logic        busy;
    logic        rd_valid;
    logic [7:0]  rd_x;
    logic [6:0]  rd_y;
    logic [2:0]  rd_colour;
    logic        op_done;
    logic [14:0] plot_count;
    logic [7:0]  oob_count;

    int checks   = 0;
    int failures = 0;

    // Reference image and statistics, updated from the plotting rules directly.
    logic [2:0] ref_mem [N];
    logic [2:0] cap     [N];
    int         ref_plot;
    int         ref_oob;

    plot_framebuffer #(.WIDTH(W), .HEIGHT(H), .CNT_W(15)) dut (
        .clk(clk), .rst(rst),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .clear_start(clear_start), .clear_colour(clear_colour), .scan_start(scan_start),
        .busy(busy), .rd_valid(rd_valid), .rd_x(rd_x), .rd_y(rd_y), .rd_colour(rd_colour),
        .op_done(op_done), .plot_count(plot_count), .oob_count(oob_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic plot(input int x, input int y, input int c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = 3'(c);
        vga_plot   = 1'b1;
        tick();
        vga_plot   = 1'b0;
        if (x < W && y < H) begin
            ref_mem[y * W + x] = 3'(c);
            if (ref_plot < 32767) ref_plot++;
        end else begin
            if (ref_oob < 255) ref_oob++;
        end
    endtask

    task automatic run_clear(input int col, input bit both, input string tag);
        int busy_n = 0;
        int done_n = 0;
        int rdv_n  = 0;
        int cyc    = 0;
        clear_colour = 3'(col);
        clear_start  = 1'b1;
        scan_start   = both;
        tick();
        clear_start  = 1'b0;
        scan_start   = 1'b0;
        while (busy === 1'b1 && cyc < 20000) begin
            busy_n++;
            if (op_done) done_n++;
            if (rd_valid) rdv_n++;
            tick();
            cyc++;
        end
        chk({tag, " op_done after last write"}, op_done, 1);
        if (op_done) done_n++;
        if (rd_valid) rdv_n++;
        tick();
        chk({tag, " op_done one cycle"}, op_done, 0);
        chk({tag, " busy cycles"}, busy_n, N);
        chk({tag, " op_done pulses"}, done_n, 1);
        chk({tag, " rd_valid cycles"}, rdv_n, 0);
        chk({tag, " busy after"}, busy, 0);
        for (int i = 0; i < N; i++) ref_mem[i] = 3'(col);
    endtask

    task automatic run_scan(input int drop_at, input string tag);
        int cyc = 0, first = -1, last = -1, nv = 0, idx = 0;
        int bad = 0, bad_idx = -1, done_n = 0, done_last = 0;
        scan_start = 1'b1;
        tick();
        scan_start = 1'b0;
        while (busy === 1'b1 && cyc < 19400) begin
            tick();
            cyc++;
            vga_plot = 1'b0;
            if (rd_valid) begin
                if (first < 0) first = cyc;
                last = cyc;
                nv++;
                if (idx < N) begin
                    if (rd_x !== 8'(idx % W) || rd_y !== 7'(idx / W) || rd_colour !== ref_mem[idx]) begin
                        bad++;
                        if (bad_idx < 0) bad_idx = idx;
                    end
                    cap[idx] = rd_colour;
                end
                idx++;
            end
            if (op_done) begin
                done_n++;
                done_last = (rd_valid && idx == N) ? 1 : 0;
            end
            if (cyc == drop_at) begin
                vga_x = 8'd10; vga_y = 7'd10; vga_colour = 3'd6; vga_plot = 1'b1;
                if (ref_oob < 255) ref_oob++;
            end
        end
        vga_plot = 1'b0;
        chk({tag, " first rd_valid cycle"}, first, 2);
        chk({tag, " rd_valid count"}, nv, N);
        chk({tag, " rd_valid contiguous"}, last - first + 1, nv);
        chk($sformatf("%s pixel mismatches (first idx %0d)", tag, bad_idx), bad, 0);
        chk({tag, " op_done pulses"}, done_n, 1);
        chk({tag, " op_done with final pixel"}, done_last, 1);
        chk({tag, " busy after"}, busy, 0);
        chk({tag, " rd_valid after"}, rd_valid, 0);
        chk({tag, " rd_x hold"}, rd_x, W - 1);
        chk({tag, " rd_y hold"}, rd_y, H - 1);
    endtask

    initial begin
        rst = 1'b1; vga_x = '0; vga_y = '0; vga_colour = '0; vga_plot = 1'b0;
        clear_start = 1'b0; clear_colour = '0; scan_start = 1'b0;
        ref_plot = 0; ref_oob = 0;
        for (int i = 0; i < N; i++) ref_mem[i] = 3'd0;
        repeat (3) tick();
        chk("reset busy", busy, 0);
        chk("reset rd_valid", rd_valid, 0);
        chk("reset op_done", op_done, 0);
        chk("reset rd_x", rd_x, 0);
        chk("reset rd_y", rd_y, 0);
        chk("reset rd_colour", rd_colour, 0);
        chk("reset plot_count", plot_count, 0);
        chk("reset oob_count", oob_count, 0);
        rst = 1'b0;
        tick();

        run_clear(0, 1'b0, "clear0");
        chk("plot_count after clear", plot_count, 0);

        for (int i = 0; i < 25; i++)
            plot($urandom_range(W - 1, 0), $urandom_range(H - 1, 0), $urandom_range(7, 0));
        plot(0, 0, 1);
        plot(159, 119, 7);
        plot(80, 60, 5);
        plot(10, 10, 3);
        chk("plot_count in-range", plot_count, ref_plot);
        chk("oob_count in-range", oob_count, 0);

        plot(160, 0, 2);
        plot(0, 120, 2);
        plot(255, 127, 2);
        chk("oob_count edges", oob_count, 3);
        chk("plot_count after oob", plot_count, ref_plot);
        for (int i = 0; i < 5; i++)
            plot($urandom_range(255, W), $urandom_range(127, 0), $urandom_range(7, 0));
        chk("oob_count random", oob_count, ref_oob);

        run_scan(500, "scan1");
        chk("pixel (0,0)", cap[0], 1);
        chk("pixel (159,119)", cap[N - 1], 7);
        chk("pixel (80,60)", cap[60 * W + 80], 5);
        chk("oob_count busy drop", oob_count, ref_oob);
        chk("plot_count busy drop", plot_count, ref_plot);

        plot(5, 0, 6);
        plot(99, 0, 2);
        plot(100, 0, 7);
        clear_colour = 3'd4;
        clear_start  = 1'b1;
        tick();
        clear_start  = 1'b0;
        repeat (100) tick();
        rst = 1'b1;
        #1;
        chk("abort busy", busy, 0);
        chk("abort op_done", op_done, 0);
        chk("abort plot_count", plot_count, 0);
        tick();
        rst = 1'b0;
        ref_plot = 0;
        ref_oob  = 0;
        for (int i = 0; i < 100; i++) ref_mem[i] = 3'd4;
        tick();
        chk("abort op_done later", op_done, 0);

        run_scan(-1, "scan2");
        chk("partial clear cell 5", cap[5], 4);
        chk("partial clear cell 99", cap[99], 4);
        chk("partial clear cell 100", cap[100], 7);
        chk("dropped plot (10,10)", cap[10 * W + 10], 3);

        run_clear(2, 1'b1, "clear+scan");

        for (int i = 0; i < 260; i++) plot(200, 5, 1);
        chk("oob_count saturates", oob_count, 255);
        chk("oob model saturates", ref_oob, 255);
        chk("plot_count final", plot_count, ref_plot);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
